// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: turns an asynchronous, possibly bouncing slow tick into
// single-cycle step strobes on the system clock, with run and halt modes
// and a wrapping strobe counter for display.
// Build option: define STEP_DEBOUNCE_EN to filter the synchronized tick
// through a DEBOUNCE_CYCLES stability window; otherwise the synchronized
// level is used directly.
module cpu_step_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned RUN_DIV         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_i,
  input  logic       mode_i,
  input  logic       halt_i,
  output logic       step_o,
  output logic [1:0] state_o,
  output logic [7:0] step_cnt_o
);

  localparam int unsigned DB_W  = 16;
  localparam int unsigned DIV_W = 16;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_e;

  // Reject parameter values the counters cannot represent
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
    $error("cpu_step_ctrl: DEBOUNCE_CYCLES out of range");
  end
  if (RUN_DIV < 2 || RUN_DIV > 65535) begin : g_bad_run_div
    $error("cpu_step_ctrl: RUN_DIV out of range");
  end

  state_e             state_q, state_d;
  logic               s1_q, s2_q;
  logic               db, db_q;
  logic               step_edge;
  logic               step_d;
  logic [DIV_W-1:0]   div_q, div_d;

  // Two-flop synchronizer for the asynchronous tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= tick_i;
      s2_q <= s1_q;
    end
  end

`ifdef STEP_DEBOUNCE_EN
  logic            db_r;
  logic [DB_W-1:0] db_cnt_q;

  // Accept a new level only after it has been stable for the full window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_r     <= 1'b0;
      db_cnt_q <= '0;
    end else if (s2_q == db_r) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      db_r     <= s2_q;
      db_cnt_q <= '0;
    end else begin
      db_cnt_q <= db_cnt_q + DB_W'(1);
    end
  end

  assign db = db_r;
`else
  // Unfiltered: the synchronized level feeds edge detection directly
  assign db = s2_q;
`endif

  // Delayed copy of the filtered level for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) db_q <= 1'b0;
    else        db_q <= db;
  end

  assign step_edge = db & ~db_q;

  // State, strobe and run divider registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      step_o  <= 1'b0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      step_o  <= step_d;
      div_q   <= div_d;
    end
  end

  // Next state, strobe source and divider; halt overrides everything
  always_comb begin
    state_d = state_q;
    step_d  = 1'b0;
    div_d   = '0;
    if (halt_i) begin
      state_d = ST_HALT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          step_d = step_edge;
          if (mode_i) state_d = ST_RUN;
        end
        ST_RUN: begin
          step_d = (div_q == DIV_W'(RUN_DIV - 1));
          if (!mode_i) state_d = ST_IDLE;
        end
        ST_HALT: begin
          if (step_edge) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (state_q == ST_RUN && state_d == ST_RUN) begin
      div_d = (div_q == DIV_W'(RUN_DIV - 1)) ? '0 : div_q + DIV_W'(1);
    end
  end

  // Count issued strobes for display, wrapping naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      step_cnt_o <= '0;
    else if (step_o) step_cnt_o <= step_cnt_o + CNT_W'(1);
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Testbench for cpu_step_ctrl: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model of the step controller.
module tb_cpu_step_ctrl;

  localparam int unsigned DEBOUNCE_CYCLES = 16;
  localparam int unsigned RUN_DIV         = 4;
`ifdef STEP_DEBOUNCE_EN
  localparam bit          DB_EN = 1'b1;
  localparam int unsigned LAT   = DEBOUNCE_CYCLES + 2;
`else
  localparam bit          DB_EN = 1'b0;
  localparam int unsigned LAT   = 2;
`endif

  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_HALT = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_i, mode_i, halt_i;
  logic       step_o;
  logic [1:0] state_o;
  logic [7:0] step_cnt_o;

  cpu_step_ctrl #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RUN_DIV        (RUN_DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_i    (tick_i),
    .mode_i    (mode_i),
    .halt_i    (halt_i),
    .step_o    (step_o),
    .state_o   (state_o),
    .step_cnt_o(step_cnt_o)
  );

  always #5 clk = ~clk;

  int n_checks  = 0;
  int n_errors  = 0;
  int cyc       = 0;
  int n_strobes = 0;
  int last_strobe = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Behavioural model: tick delayed two edges, level accepted once the last
  // DEBOUNCE_CYCLES synchronized samples agree, run strobe every RUN_DIV-th
  // edge spent in run.
  bit m_s1, m_s2, m_db, m_dbq, m_step;
  bit win[$];
  int m_st, m_run_k, m_cnt;

  function automatic void model_reset();
    m_s1 = 0; m_s2 = 0; m_db = 0; m_dbq = 0; m_step = 0;
    m_st = S_IDLE; m_run_k = 0; m_cnt = 0;
    win.delete();
  endfunction

  function automatic void model_step();
    bit db_now, rise, nstep, agree;
    int nst;
    db_now = DB_EN ? m_db : m_s2;
    rise   = db_now && !m_dbq;
    if (halt_i) begin
      nst = S_HALT; nstep = 0;
    end else if (m_st == S_IDLE) begin
      nstep = rise; nst = mode_i ? S_RUN : S_IDLE;
    end else if (m_st == S_RUN) begin
      nstep = ((m_run_k + 1) % RUN_DIV) == 0; nst = mode_i ? S_RUN : S_IDLE;
    end else begin
      nstep = 0; nst = rise ? S_IDLE : S_HALT;
    end
    m_run_k = (m_st == S_RUN && nst == S_RUN) ? m_run_k + 1 : 0;
    m_cnt   = (m_cnt + int'(m_step)) % 256;
    m_step  = nstep;
    m_st    = nst;
    win.push_back(m_s2);
    if (win.size() > DEBOUNCE_CYCLES) void'(win.pop_front());
    if (win.size() == DEBOUNCE_CYCLES) begin
      agree = 1;
      foreach (win[k]) if (win[k] != win[0]) agree = 0;
      if (agree && win[0] != m_db) m_db = win[0];
    end
    m_dbq = db_now;
    m_s2  = m_s1;
    m_s1  = tick_i;
  endfunction

  // Drive one cycle of inputs, advance the model, then compare after the edge
  task automatic cycle(input bit t, input bit m, input bit h);
    tick_i = t; mode_i = m; halt_i = h;
    model_step();
    cyc++;
    @(negedge clk);
    chk("step_o", step_o, 32'(m_step));
    chk("state_o", state_o, 32'(m_st));
    chk("step_cnt_o", step_cnt_o, 32'(m_cnt));
    if (step_o === 1'b1) begin
      n_strobes++;
      last_strobe = cyc;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulse(input int hi, input int lo);
    repeat (hi) cycle(1'b1, 1'b0, 1'b0);
    repeat (lo) cycle(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int t1, base;
    bit rm, rt, rh;
    int len;
    rst_n = 1'b1; tick_i = 1'b0; mode_i = 1'b0; halt_i = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_step_o", step_o, 0);
    chk("rst_state_o", state_o, 0);
    chk("rst_step_cnt_o", step_cnt_o, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Clean 40-cycle pulse: one strobe at the fixed latency
    idle(40);
    n_strobes = 0;
    t1 = cyc + 1;
    pulse(40, 40);
    chk("clean_count", n_strobes, 1);
    chk("clean_latency", last_strobe - t1, LAT);
    chk("clean_cnt", step_cnt_o, 1);

    // Bouncing tick, then settled high
    n_strobes = 0;
    repeat (6) pulse(5, 5);
    chk("bounce_strobes", n_strobes, DB_EN ? 0 : 6);
    n_strobes = 0;
    pulse(40, 40);
    chk("settle_strobes", n_strobes, 1);

    // Run mode for 20 cycles with a tick pulse that must be ignored
    n_strobes = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(i >= 1 && i <= 18, 1'b1, 1'b0);
      if (i == 10) chk("run_state", state_o, S_RUN);
    end
    idle(6);
    chk("run_strobes", n_strobes, 5);
    chk("run_exit_state", state_o, S_IDLE);

    // Halt from run, acknowledge with one tick, step with the next
    idle(40);
    repeat (6) cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1);
    chk("halt_state", state_o, S_HALT);
    n_strobes = 0;
    repeat (10) cycle(1'b0, 1'b1, 1'b1);
    idle(5);
    chk("halt_hold", state_o, S_HALT);
    pulse(30, 30);
    chk("ack_state", state_o, S_IDLE);
    chk("ack_nostrobe", n_strobes, 0);
    pulse(30, 30);
    chk("after_ack", n_strobes, 1);

    // Halt arriving on the same edge as a step edge: no strobe, go to halt
    n_strobes = 0;
    for (int i = 0; i < 40; i++) cycle(i < 30, 1'b0, i == int'(LAT));
    chk("halt_edge_strobe", n_strobes, 0);
    chk("halt_edge_state", state_o, S_HALT);
    pulse(30, 30);
    chk("halt_edge_ack", state_o, S_IDLE);

    // Asynchronous reset mid-debounce with the tick still high afterwards
    idle(40);
    repeat (8) cycle(1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_step_o", step_o, 0);
    chk("async_state_o", state_o, 0);
    chk("async_step_cnt_o", step_cnt_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    n_strobes = 0;
    repeat (30) cycle(1'b1, 1'b0, 1'b0);
    chk("post_rst_strobe", n_strobes, 1);
    idle(30);

    // Counter wrap: 256 strobes since reset bring it back to 0
    base = 1;
    repeat (255) pulse(20, 20);
    chk("wrap_strobes", n_strobes, 256);
    chk("wrap_cnt", step_cnt_o, (base + 255) % 256);

    // Single-cycle glitch
    idle(40);
    n_strobes = 0;
    cycle(1'b1, 1'b0, 1'b0);
    idle(30);
    chk("glitch", n_strobes, DB_EN ? 0 : 1);

    // Randomized traffic against the model
    rm = 1'b0;
    for (int b = 0; b < 150; b++) begin
      len = int'($urandom_range(1, 30));
      rt  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) rm = ~rm;
      rh  = ($urandom_range(0, 9) == 0);
      repeat (len) cycle(rt, rm, rh);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
